// File: rtl/pcie_tag_occupancy_checker.sv
// Tracks outstanding MRd tags against returning completions and flags illegal,
// reused and unexpected tags, with sticky bits and a first-error capture.
module pcie_tag_occupancy_checker #(
    parameter int TAG_W                     = 10,
    parameter int PCIE_EP_MAX_TAGS          = 96,
    parameter bit ENABLE_TAG_OCCUPIED_CHECK = 1'b1,
    parameter int CNT_W                     = $clog2(PCIE_EP_MAX_TAGS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    input  logic [TAG_W-1:0] i_req_tag,
    input  logic             i_cpl_valid,
    input  logic [TAG_W-1:0] i_cpl_tag,
    input  logic             i_cpl_last,
    input  logic             i_err_clr,
    output logic             o_max_tag_err,
    output logic             o_tag_occupied_err,
    output logic             o_unexp_cpl_err,
    output logic [2:0]       o_err_sticky,
    output logic [1:0]       o_first_err_code,
    output logic [TAG_W-1:0] o_first_err_tag,
    output logic [CNT_W-1:0] o_outstanding,
    output logic             o_tags_full
);

    localparam logic [TAG_W:0] MAX_TAGS = (TAG_W + 1)'(PCIE_EP_MAX_TAGS);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PCIE_EP_MAX_TAGS);

    logic [PCIE_EP_MAX_TAGS-1:0] r_bitmap;
    logic [PCIE_EP_MAX_TAGS-1:0] w_req_dec;
    logic [PCIE_EP_MAX_TAGS-1:0] w_cpl_dec;
    logic [PCIE_EP_MAX_TAGS-1:0] w_post_cpl;
    logic [PCIE_EP_MAX_TAGS-1:0] w_bitmap_next;

    logic             w_req_legal, w_cpl_legal;
    logic             w_cpl_hit, w_req_occ;
    logic             w_alloc, w_free;
    logic             w_max_tag, w_occupied, w_unexp;
    logic [CNT_W-1:0] w_count_next;
    logic [2:0]       w_sticky_base;
    logic [1:0]       w_code_base;

    assign w_req_legal = {1'b0, i_req_tag} < MAX_TAGS;
    assign w_cpl_legal = {1'b0, i_cpl_tag} < MAX_TAGS;

    // Per-tag decode; an out-of-range tag decodes to all zeros, so no bit is touched.
    generate
        for (genvar gi = 0; gi < PCIE_EP_MAX_TAGS; gi++) begin : g_tag
            assign w_req_dec[gi]     = (i_req_tag == TAG_W'(gi));
            assign w_cpl_dec[gi]     = (i_cpl_tag == TAG_W'(gi));
            assign w_post_cpl[gi]    = r_bitmap[gi] & ~(w_free & w_cpl_dec[gi]);
            assign w_bitmap_next[gi] = w_post_cpl[gi] | (w_alloc & w_req_dec[gi]);
        end
    endgenerate

    // Completion is judged against the current bitmap, the request against the post-cpl one.
    assign w_cpl_hit = w_cpl_legal & |(r_bitmap & w_cpl_dec);
    assign w_free    = i_cpl_valid & w_cpl_hit & i_cpl_last;
    assign w_req_occ = |(w_post_cpl & w_req_dec);
    assign w_alloc   = i_req_valid & w_req_legal & ~w_req_occ;

    assign w_max_tag  = i_req_valid & ~w_req_legal;
    assign w_occupied = ENABLE_TAG_OCCUPIED_CHECK & i_req_valid & w_req_legal & w_req_occ;
    assign w_unexp    = ENABLE_TAG_OCCUPIED_CHECK & i_cpl_valid & ~w_cpl_hit;

    assign w_count_next  = o_outstanding + CNT_W'(w_alloc) - CNT_W'(w_free);
    assign w_sticky_base = i_err_clr ? 3'b000 : o_err_sticky;
    assign w_code_base   = i_err_clr ? 2'd0 : o_first_err_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bitmap           <= '0;
            o_outstanding      <= '0;
            o_tags_full        <= 1'b0;
            o_max_tag_err      <= 1'b0;
            o_tag_occupied_err <= 1'b0;
            o_unexp_cpl_err    <= 1'b0;
            o_err_sticky       <= 3'b000;
            o_first_err_code   <= 2'd0;
            o_first_err_tag    <= '0;
        end else begin
            r_bitmap           <= w_bitmap_next;
            o_outstanding      <= w_count_next;
            o_tags_full        <= (w_count_next == FULL_CNT);
            o_max_tag_err      <= w_max_tag;
            o_tag_occupied_err <= w_occupied;
            o_unexp_cpl_err    <= w_unexp;
            o_err_sticky       <= w_sticky_base | {w_unexp, w_occupied, w_max_tag};
            o_first_err_code   <= w_code_base;
            if (i_err_clr) begin
                o_first_err_tag <= '0;
            end
            if (w_code_base == 2'd0) begin
                if (w_max_tag) begin
                    o_first_err_code <= 2'd1;
                    o_first_err_tag  <= i_req_tag;
                end else if (w_occupied) begin
                    o_first_err_code <= 2'd2;
                    o_first_err_tag  <= i_req_tag;
                end else if (w_unexp) begin
                    o_first_err_code <= 2'd3;
                    o_first_err_tag  <= i_cpl_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcie_tag_occupancy_checker.sv
// Directed bench: one task per scenario, checking the checked and unchecked variants.
module tb_pcie_tag_occupancy_checker;

    localparam int TAG_W = 10;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_req_valid, i_cpl_valid, i_cpl_last, i_err_clr;
    logic [TAG_W-1:0] i_req_tag, i_cpl_tag;

    logic             max_e, occ_e, unx_e, full;
    logic [2:0]       sticky;
    logic [1:0]       code;
    logic [TAG_W-1:0] ftag;
    logic [CNT_W-1:0] cnt;

    logic             nc_max_e, nc_occ_e, nc_unx_e, nc_full;
    logic [2:0]       nc_sticky;
    logic [1:0]       nc_code;
    logic [TAG_W-1:0] nc_ftag;
    logic [CNT_W-1:0] nc_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pcie_tag_occupancy_checker #(.TAG_W(TAG_W), .PCIE_EP_MAX_TAGS(96), .ENABLE_TAG_OCCUPIED_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_tag(i_req_tag),
        .i_cpl_valid(i_cpl_valid), .i_cpl_tag(i_cpl_tag), .i_cpl_last(i_cpl_last),
        .i_err_clr(i_err_clr),
        .o_max_tag_err(max_e), .o_tag_occupied_err(occ_e), .o_unexp_cpl_err(unx_e),
        .o_err_sticky(sticky), .o_first_err_code(code), .o_first_err_tag(ftag),
        .o_outstanding(cnt), .o_tags_full(full)
    );

    pcie_tag_occupancy_checker #(.TAG_W(TAG_W), .PCIE_EP_MAX_TAGS(96), .ENABLE_TAG_OCCUPIED_CHECK(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_tag(i_req_tag),
        .i_cpl_valid(i_cpl_valid), .i_cpl_tag(i_cpl_tag), .i_cpl_last(i_cpl_last),
        .i_err_clr(i_err_clr),
        .o_max_tag_err(nc_max_e), .o_tag_occupied_err(nc_occ_e), .o_unexp_cpl_err(nc_unx_e),
        .o_err_sticky(nc_sticky), .o_first_err_code(nc_code), .o_first_err_tag(nc_ftag),
        .o_outstanding(nc_cnt), .o_tags_full(nc_full)
    );

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_req_tag = '0;
        i_cpl_valid = 1'b0; i_cpl_tag = '0; i_cpl_last = 1'b0;
        i_err_clr   = 1'b0;
    endtask

    task automatic step(input bit rv, input int rt, input bit cv, input int ct, input bit cl, input bit clr);
        i_req_valid = rv; i_req_tag = TAG_W'(rt);
        i_cpl_valid = cv; i_cpl_tag = TAG_W'(ct); i_cpl_last = cl;
        i_err_clr   = clr;
        tick();
        idle_inputs();
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (cnt !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if ({max_e, occ_e, unx_e} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {max_e, occ_e, unx_e}); end
        checks++; if (sticky !== 3'b000 || code !== 2'd0 || ftag !== 10'd0) begin errors++; $display("FAIL reset_capture got sticky=%b code=%0d tag=%0d exp 0/0/0", sticky, code, ftag); end
        $display("test_reset: count=%0d sticky=%b code=%0d", cnt, sticky, code);
    endtask

    task automatic test_fill();
        apply_reset();
        for (int t = 0; t < 96; t++) step(1'b1, t, 1'b0, 0, 1'b0, 1'b0);
        checks++; if (cnt !== 7'd96) begin errors++; $display("FAIL fill_count got=%0d exp=96", cnt); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%0b exp=1", full); end
        checks++; if (sticky !== 3'b000) begin errors++; $display("FAIL fill_sticky got=%b exp=000", sticky); end
        step(1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
        checks++; if (cnt !== 7'd95) begin errors++; $display("FAIL free5_count got=%0d exp=95", cnt); end
        checks++; if (full !== 1'b0 || unx_e !== 1'b0) begin errors++; $display("FAIL free5_flags got full=%0b unexp=%0b exp 0/0", full, unx_e); end
        $display("test_fill: count=%0d full=%0b", cnt, full);
    endtask

    task automatic test_dup_tag();
        apply_reset();
        step(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        checks++; if (occ_e !== 1'b0) begin errors++; $display("FAIL dup_first_pulse got=%0b exp=0", occ_e); end
        step(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        checks++; if (occ_e !== 1'b1) begin errors++; $display("FAIL dup_pulse got=%0b exp=1", occ_e); end
        checks++; if (sticky !== 3'b010 || code !== 2'd2 || ftag !== 10'd7) begin errors++; $display("FAIL dup_capture got sticky=%b code=%0d tag=%0d exp 010/2/7", sticky, code, ftag); end
        checks++; if (cnt !== 7'd1) begin errors++; $display("FAIL dup_count got=%0d exp=1", cnt); end
        tick();
        checks++; if (occ_e !== 1'b0 || sticky !== 3'b010) begin errors++; $display("FAIL dup_hold got pulse=%0b sticky=%b exp 0/010", occ_e, sticky); end
        $display("test_dup_tag: sticky=%b code=%0d tag=%0d", sticky, code, ftag);
    endtask

    task automatic test_max_tag();
        apply_reset();
        step(1'b1, 96, 1'b0, 0, 1'b0, 1'b0);
        checks++; if (max_e !== 1'b1) begin errors++; $display("FAIL max_pulse got=%0b exp=1", max_e); end
        checks++; if (code !== 2'd1 || ftag !== 10'd96 || cnt !== 7'd0) begin errors++; $display("FAIL max_capture got code=%0d tag=%0d count=%0d exp 1/96/0", code, ftag, cnt); end
        step(1'b0, 0, 1'b1, 200, 1'b1, 1'b0);
        checks++; if (unx_e !== 1'b1 || max_e !== 1'b0) begin errors++; $display("FAIL cpl200_pulses got unexp=%0b max=%0b exp 1/0", unx_e, max_e); end
        checks++; if (sticky !== 3'b101 || code !== 2'd1 || ftag !== 10'd96) begin errors++; $display("FAIL cpl200_capture got sticky=%b code=%0d tag=%0d exp 101/1/96", sticky, code, ftag); end
        $display("test_max_tag: sticky=%b code=%0d tag=%0d", sticky, code, ftag);
    endtask

    task automatic test_priority();
        apply_reset();
        step(1'b1, 96, 1'b1, 10, 1'b1, 1'b0);
        checks++; if (code !== 2'd1 || ftag !== 10'd96 || sticky !== 3'b101) begin errors++; $display("FAIL prio_max_unexp got code=%0d tag=%0d sticky=%b exp 1/96/101", code, ftag, sticky); end
        apply_reset();
        step(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 7, 1'b1, 8, 1'b1, 1'b0);
        checks++; if (code !== 2'd2 || ftag !== 10'd7 || sticky !== 3'b110) begin errors++; $display("FAIL prio_occ_unexp got code=%0d tag=%0d sticky=%b exp 2/7/110", code, ftag, sticky); end
        $display("test_priority: code=%0d tag=%0d", code, ftag);
    endtask

    task automatic test_same_cycle();
        apply_reset();
        step(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 3, 1'b1, 3, 1'b1, 1'b0);
        checks++; if ({max_e, occ_e, unx_e} !== 3'b000 || cnt !== 7'd1) begin errors++; $display("FAIL req_cpl_same got pulses=%b count=%0d exp 000/1", {max_e, occ_e, unx_e}, cnt); end
        step(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
        checks++; if (unx_e !== 1'b0 || cnt !== 7'd1) begin errors++; $display("FAIL nonlast_hit got unexp=%0b count=%0d exp 0/1", unx_e, cnt); end
        step(1'b0, 0, 1'b1, 4, 1'b0, 1'b0);
        checks++; if (unx_e !== 1'b1 || cnt !== 7'd1 || code !== 2'd3 || ftag !== 10'd4) begin errors++; $display("FAIL nonlast_free got unexp=%0b count=%0d code=%0d tag=%0d exp 1/1/3/4", unx_e, cnt, code, ftag); end
        step(1'b0, 0, 1'b1, 3, 1'b1, 1'b0);
        checks++; if (cnt !== 7'd0 || unx_e !== 1'b0) begin errors++; $display("FAIL last_free3 got count=%0d unexp=%0b exp 0/0", cnt, unx_e); end
        $display("test_same_cycle: count=%0d sticky=%b", cnt, sticky);
    endtask

    task automatic test_err_clr();
        apply_reset();
        step(1'b1, 1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 96, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 9, 1'b1, 1'b1);
        checks++; if (sticky !== 3'b100 || code !== 2'd3 || ftag !== 10'd9) begin errors++; $display("FAIL clr_and_err got sticky=%b code=%0d tag=%0d exp 100/3/9", sticky, code, ftag); end
        step(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        checks++; if (sticky !== 3'b000 || code !== 2'd0) begin errors++; $display("FAIL clr_only got sticky=%b code=%0d exp 000/0", sticky, code); end
        checks++; if (cnt !== 7'd1) begin errors++; $display("FAIL clr_count got=%0d exp=1", cnt); end
        $display("test_err_clr: sticky=%b code=%0d count=%0d", sticky, code, cnt);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int t = 0; t < 10; t++) step(1'b1, t, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 200, 1'b0, 0, 1'b0, 1'b0);
        checks++; if (cnt !== 7'd10 || sticky !== 3'b001) begin errors++; $display("FAIL pre_reset got count=%0d sticky=%b exp 10/001", cnt, sticky); end
        apply_reset();
        checks++; if (cnt !== 7'd0 || sticky !== 3'b000) begin errors++; $display("FAIL mid_reset got count=%0d sticky=%b exp 0/000", cnt, sticky); end
        step(1'b0, 0, 1'b1, 2, 1'b1, 1'b0);
        checks++; if (unx_e !== 1'b1 || cnt !== 7'd0) begin errors++; $display("FAIL stale_cpl got unexp=%0b count=%0d exp 1/0", unx_e, cnt); end
        $display("test_reset_mid: count=%0d unexp=%0b", cnt, unx_e);
    endtask

    task automatic test_no_occ_check();
        apply_reset();
        step(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        checks++; if (nc_occ_e !== 1'b0 || nc_cnt !== 7'd1 || nc_sticky !== 3'b000) begin errors++; $display("FAIL nc_dup got pulse=%0b count=%0d sticky=%b exp 0/1/000", nc_occ_e, nc_cnt, nc_sticky); end
        step(1'b0, 0, 1'b1, 4, 1'b0, 1'b0);
        checks++; if (nc_unx_e !== 1'b0 || nc_code !== 2'd0) begin errors++; $display("FAIL nc_unexp got pulse=%0b code=%0d exp 0/0", nc_unx_e, nc_code); end
        step(1'b0, 0, 1'b1, 7, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 7, 1'b1, 1'b0);
        checks++; if (nc_cnt !== 7'd0 || nc_unx_e !== 1'b0) begin errors++; $display("FAIL nc_refree got count=%0d pulse=%0b exp 0/0", nc_cnt, nc_unx_e); end
        step(1'b1, 100, 1'b0, 0, 1'b0, 1'b0);
        checks++; if (nc_max_e !== 1'b1 || nc_sticky !== 3'b001 || nc_code !== 2'd1) begin errors++; $display("FAIL nc_max got pulse=%0b sticky=%b code=%0d exp 1/001/1", nc_max_e, nc_sticky, nc_code); end
        $display("test_no_occ_check: count=%0d sticky=%b", nc_cnt, nc_sticky);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        test_reset();
        test_fill();
        test_dup_tag();
        test_max_tag();
        test_priority();
        test_same_cycle();
        test_err_clr();
        test_reset_mid();
        test_no_occ_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
